// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the debounce bank.
package debounce_pkg;

    localparam int   DEF_STABLE_CNT = 180000;
    localparam logic DEF_IDLE_LVL   = 1'b1;

    // Smallest width able to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounced channel: 2-flop synchroniser, stability counter, output flop and edge pulses.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int   STABLE_CNT = DEF_STABLE_CNT,
    parameter logic IDLE_LVL   = DEF_IDLE_LVL
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic sw_in,
    output logic sw_out,
    output logic rise,
    output logic fall,
    output logic evt_next
);

    localparam int               CNT_W   = clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;

    logic             w_out_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_rise_next;
    logic             w_fall_next;

    // Agreement clears the count even while ce is low, so a glitch never accumulates.
    always_comb begin
        w_out_next  = r_out;
        w_cnt_next  = r_cnt;
        w_rise_next = 1'b0;
        w_fall_next = 1'b0;
        if (r_sync == r_out) begin
            w_cnt_next = '0;
        end else if (ce) begin
            if (r_cnt == CNT_MAX) begin
                w_out_next  = r_sync;
                w_cnt_next  = '0;
                w_rise_next = r_sync;
                w_fall_next = ~r_sync;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= IDLE_LVL;
            r_sync <= IDLE_LVL;
            r_out  <= IDLE_LVL;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= sw_in;
            r_sync <= r_meta;
            r_out  <= w_out_next;
            r_cnt  <= w_cnt_next;
            r_rise <= w_rise_next;
            r_fall <= w_fall_next;
        end
    end

    assign sw_out   = r_out;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign evt_next = w_rise_next | w_fall_next;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced switch inputs with a shared registered event flag.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   N_CH       = 8,
    parameter int   STABLE_CNT = DEF_STABLE_CNT,
    parameter logic IDLE_LVL   = DEF_IDLE_LVL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_evt
);

    logic [N_CH-1:0] w_evt_next;
    logic            r_any_evt;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_ch #(
                .STABLE_CNT (STABLE_CNT),
                .IDLE_LVL   (IDLE_LVL)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .ce       (ce),
                .sw_in    (sw_in[gi]),
                .sw_out   (sw_out[gi]),
                .rise     (rise[gi]),
                .fall     (fall[gi]),
                .evt_next (w_evt_next[gi])
            );
        end
    endgenerate

    // Built from the channels' next-pulse terms so the flag lands with the pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_evt <= 1'b0;
        end else begin
            r_any_evt <= |w_evt_next;
        end
    end

    assign any_evt = r_any_evt;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed stimulus for debounce_bank with an event scoreboard checked by a separate monitor.
module tb_debounce_bank;

    localparam int N  = 4;
    localparam int SC = 4;

    logic         clk;
    logic         rst;
    logic         ce;
    logic [N-1:0] sw_in;
    logic [N-1:0] sw_out;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         any_evt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int           at;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] lvl;
    } exp_t;

    exp_t exp_q[$];

    debounce_bank #(
        .N_CH       (N),
        .STABLE_CNT (SC),
        .IDLE_LVL   (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .sw_in   (sw_in),
        .sw_out  (sw_out),
        .rise    (rise),
        .fall    (fall),
        .any_evt (any_evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic expect_evt(input int at, input logic [N-1:0] r, input logic [N-1:0] f,
                              input logic [N-1:0] lvl);
        exp_t e;
        e.at   = at;
        e.rise = r;
        e.fall = f;
        e.lvl  = lvl;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle showing a pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (any_evt || (|rise) || (|fall)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", {24'd0, rise, fall}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("evt_cycle", cyc, e.at);
                chk("evt_rise", 32'(rise), 32'(e.rise));
                chk("evt_fall", 32'(fall), 32'(e.fall));
                chk("evt_sw_out", 32'(sw_out), 32'(e.lvl));
                chk("evt_any", 32'(any_evt), 32'd1);
                $display("evt cyc=%0d rise=%b fall=%b sw_out=%b any_evt=%b", cyc, rise, fall,
                         sw_out, any_evt);
            end
        end
    end

    initial begin
        int c;
        rst   = 1'b1;
        ce    = 1'b1;
        sw_in = 4'b1111;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle inputs: nothing may move.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_state", {20'd0, sw_out, rise, fall}, {20'd0, 4'b1111, 4'b0000, 4'b0000});
            chk("idle_any", 32'(any_evt), 32'd0);
        end
        $display("idle check done cyc=%0d", cyc);

        // ch0 falls; visible 6 negedges after the drive point.
        c = cyc;
        sw_in[0] = 1'b0;
        expect_evt(c + 6, 4'b0000, 4'b0001, 4'b1110);
        repeat (10) @(negedge clk);

        // ch1 glitch of 3 cycles must not qualify.
        sw_in[1] = 1'b0;
        repeat (3) @(negedge clk);
        sw_in[1] = 1'b1;
        repeat (8) @(negedge clk);
        chk("glitch_sw_out", 32'(sw_out), 32'(4'b1110));
        $display("glitch check cyc=%0d sw_out=%b", cyc, sw_out);

        // ch2 and ch3 fall together, then rise together.
        c = cyc;
        sw_in = 4'b0010;
        expect_evt(c + 6, 4'b0000, 4'b1100, 4'b0010);
        repeat (10) @(negedge clk);
        c = cyc;
        sw_in = 4'b1110;
        expect_evt(c + 6, 4'b1100, 4'b0000, 4'b1110);
        repeat (10) @(negedge clk);

        // ch0 back high with ce=1.
        c = cyc;
        sw_in = 4'b1111;
        expect_evt(c + 6, 4'b0001, 4'b0000, 4'b1111);
        repeat (10) @(negedge clk);

        // ce high one cycle in three: qualifies on the 4th ce edge after sync differs.
        while ((cyc % 3) != 0) @(negedge clk);
        c = cyc;
        expect_evt(c + 13, 4'b0000, 4'b0001, 4'b1110);
        for (int i = 0; i < 18; i++) begin
            ce = ((cyc % 3) == 0);
            if (i == 0) sw_in[0] = 1'b0;
            @(negedge clk);
        end
        ce = 1'b1;
        repeat (4) @(negedge clk);

        // Reset while ch1 counts at cnt=2: partial count discarded, no pulse.
        c = cyc;
        sw_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_state", {20'd0, sw_out, rise, fall}, {20'd0, 4'b1111, 4'b0000, 4'b0000});
        chk("rst_any", 32'(any_evt), 32'd0);
        $display("reset check cyc=%0d sw_out=%b", cyc, sw_out);
        rst = 1'b0;
        c = cyc;
        expect_evt(c + 6, 4'b0000, 4'b0011, 4'b1100);
        repeat (10) @(negedge clk);

        c = cyc;
        sw_in = 4'b1111;
        expect_evt(c + 6, 4'b0011, 4'b0000, 4'b1111);
        repeat (10) @(negedge clk);

        chk("pending_events", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 8: number of independent input channels (1..32).
REQ-002 Parameter STABLE_CNT, default 180000: qualified ce cycles an input must hold a new level before the output follows (2..2^20).
REQ-003 Parameter IDLE_LVL, default 1: per-channel reset level of synchroniser and outputs (buttons idle high).
REQ-004 Localparam CNT_W = clog2(STABLE_CNT): counter width.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 ce  input  1  count enable; tie high for per-clk counting, or drive a 1-cycle prescaler tick.
REQ-009 sw_in  input  N_CH  raw asynchronous switch/button levels.
REQ-010 sw_out  output  N_CH  debounced levels, registered.
REQ-011 rise  output  N_CH  1-cycle pulse per channel when sw_out goes 0->1.
REQ-012 fall  output  N_CH  1-cycle pulse per channel when sw_out goes 1->0.
REQ-013 any_evt  output  1  registered OR of all rise and fall bits, same cycle as the pulses.

Function
REQ-014 Each channel SHALL pass sw_in through a 2-flop synchroniser; the second stage is sync.
REQ-015 Each channel SHALL hold a CNT_W-bit counter cnt; when sync == sw_out, cnt <= 0 every cycle regardless of ce.
REQ-016 When sync != sw_out and ce = 1 and cnt < STABLE_CNT-1: cnt <= cnt+1.
REQ-017 When sync != sw_out and ce = 1 and cnt == STABLE_CNT-1: sw_out <= sync, cnt <= 0, and the matching rise/fall bit is 1 in the same cycle sw_out first shows the new value.
REQ-018 When ce = 0: cnt and sw_out hold; pulses are 0.
REQ-019 Any glitch returning sync to sw_out before qualification restarts cnt at 0; no output change, no pulse.
REQ-020 With ce tied high, a pad change sampled at edge k appears on sw_out after edge k+1+STABLE_CNT.
REQ-021 rise and fall for one channel SHALL never both be 1; each is high exactly one cycle per transition.
REQ-022 Channels SHALL be fully independent; simultaneous qualification on several channels produces simultaneous pulses and one any_evt cycle.
REQ-023 cnt SHALL never exceed STABLE_CNT-1; no wrap-around is possible.

Reset
REQ-024 On rst = 1 at a clock edge: synchronisers and sw_out <= IDLE_LVL replicated, cnt <= 0, rise/fall/any_evt <= 0.
REQ-025 Reset mid-qualification SHALL discard the partial count; no pulse is emitted during or on the cycle after reset.
REQ-026 If sw_in differs from IDLE_LVL after reset, full qualification (REQ-020) is required before sw_out changes.

Structure
REQ-027 Shared package debounce_pkg holds the default STABLE_CNT, the default IDLE_LVL and a clog2 helper function.
REQ-028 Per-channel logic (synchroniser, counter, output flop, edge pulses) SHALL be one sub-module debounce_ch, generated N_CH times.
REQ-029 any_evt SHALL be the only cross-channel logic, implemented in debounce_bank.

Verification (N_CH=4, STABLE_CNT=4, IDLE_LVL=1, ce=1 unless stated)
REQ-030 Reset, sw_in=4'b1111 held -> sw_out=4'b1111, rise=fall=0, any_evt=0 for 20 cycles.
REQ-031 sw_in[0] 1->0 sampled at edge 0, then held -> sw_out[0]=0 after edge 5; fall[0]=1 only in that cycle; any_evt=1 in that cycle.
REQ-032 sw_in[1] low for 3 cycles, then back high -> sw_out[1] stays 1; no pulses.
REQ-033 sw_in[2] and sw_in[3] switched 1->0 in the same cycle -> both fall in one cycle, a single any_evt cycle; later 0->1 gives rise[2] and rise[3] together.
REQ-034 ce pulsed 1 cycle in 3, sw_in[0] 1->0 -> sw_out[0] changes on the 4th ce-high edge after sync differs; holds while ce=0.
REQ-035 rst asserted when cnt=2 during a transition -> cnt=0, sw_out=IDLE_LVL, no pulse; qualification restarts from 0 after rst drops.
